fetch_unit: RTL and testbench

Program-counter and fetch-control stage of the single-cycle RV32I core, directly upstream of the instruction memory. Holds the architectural PC, drives the byte address into instruction memory, and selects the next PC from the datapath's branch/jump resolution. Detects the self-loop halt idiom, traps on misaligned, out-of-range or all-zero fetches, and counts retired instructions for the testbench.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/next_pc_sel.sv | 56 +++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      TRAP = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      NONE         = 2'd0,
      MISALIGNED   = 2'd1,
      OUT_OF_RANGE = 2'd2,
      ZERO_WORD    = 2'd3
   } trap_cause_t;

   // beq x0,x0,0: a branch to itself, used by programs to signal completion
   localparam logic [31:0] HALT_INSTR = 32'h0000_0063;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux (jalr > jal > branch > sequential) with alignment and range checks.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides whether the result is committed.
module next_pc_sel
   import fetch_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int IMEM_BYTES = 4096
) (
   input  logic [WIDTH-1:0] pc,
   input  logic             branch_taken,
   input  logic             jal,
   input  logic             jalr,
   input  logic [WIDTH-1:0] branch_target,
   input  logic [WIDTH-1:0] jalr_target,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] next_pc,
   output logic [1:0]       fault
);

   // one extra bit so a sequential step past the top of the address space is visible
   localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(IMEM_BYTES);

   logic [WIDTH:0] seq_sum;
   logic           wrap;
   logic           jalr_lsb_unused;

   assign seq_sum         = {1'b0, pc} + (WIDTH+1)'(4);
   assign pc_plus4        = seq_sum[WIDTH-1:0];
   // JALR discards bit 0 of its target by definition
   assign jalr_lsb_unused = jalr_target[0];

   // priority target selection; only the sequential path can wrap
   always_comb begin
      next_pc = pc_plus4;
      wrap    = 1'b0;
      if (jalr) begin
         next_pc = {jalr_target[WIDTH-1:1], 1'b0};
      end else if (jal || branch_taken) begin
         next_pc = branch_target;
      end else begin
         wrap = seq_sum[WIDTH];
      end
   end

   // misalignment outranks range so a bad odd target reports the more specific cause
   always_comb begin
      fault = NONE;
      if (next_pc[1:0] != 2'b00) begin
         fault = MISALIGNED;
      end else if (wrap || ({1'b0, next_pc} >= LIMIT)) begin
         fault = OUT_OF_RANGE;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// PC register and fetch control for the single-cycle RV32I core, with halt/trap detection.
// Latency: retire is combinational; pc, state and counter update on the next rising edge.
// Backpressure: stall holds every register; HALT and TRAP freeze fetch until reset.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter int               IMEM_BYTES = 4096,
   parameter int               CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [WIDTH-1:0] instr,
   input  logic             branch_taken,
   input  logic             jal,
   input  logic             jalr,
   input  logic [WIDTH-1:0] branch_target,
   input  logic [WIDTH-1:0] jalr_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             retire,
   output logic             halted,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired_count
);

   fetch_state_t     state_q, state_d;
   trap_cause_t      cause_q, cause_d;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] next_pc;
   logic [1:0]       sel_fault;
   logic [CNT_W-1:0] cnt_q;
   logic             active;
   logic             zero_word;
   logic             halt_word;

   next_pc_sel #(
      .WIDTH      (WIDTH),
      .IMEM_BYTES (IMEM_BYTES)
   ) u_next_pc_sel (
      .pc            (pc_q),
      .branch_taken  (branch_taken),
      .jal           (jal),
      .jalr          (jalr),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_pc),
      .fault         (sel_fault)
   );

   assign active        = (state_q == RUN) && !stall;
   assign zero_word     = (instr == '0);
   assign halt_word     = (instr == WIDTH'(HALT_INSTR));
   assign pc            = pc_q;
   assign trap_cause    = cause_q;
   assign retired_count = cnt_q;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and trap cause; a zero word is checked before any PC fault
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      if (active) begin
         if (zero_word) begin
            state_d = TRAP;
            cause_d = ZERO_WORD;
         end else if (sel_fault != 2'b00) begin
            state_d = TRAP;
            cause_d = trap_cause_t'(sel_fault);
         end else if (halt_word) begin
            state_d = HALT;
         end
      end
   end

   // state-decoded outputs; retire needs a running, unstalled, fault-free cycle
   always_comb begin
      retire = 1'b0;
      halted = 1'b0;
      trap   = 1'b0;
      case (state_q)
         RUN:     retire = !stall && !zero_word && (sel_fault == 2'b00);
         HALT:    halted = 1'b1;
         TRAP:    trap   = 1'b1;
         default: ;
      endcase
   end

   // PC, cause and retired counter; the halt instruction retires but leaves the PC in place
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         cause_q <= NONE;
      end else begin
         cause_q <= cause_d;
         if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!halt_word) begin
               pc_q <= next_pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic vs a reference model.
// Latency: inputs applied 1 time unit after a rising edge, outputs checked before the next edge.
// Backpressure: stall and reset are exercised both directed and at random.
module tb_fetch_unit;

   localparam int IMEM = 4096;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT_WORD = 32'h0000_0063;

   logic        clk = 1'b0;
   logic        rst, stall, branch_taken, jal, jalr;
   logic [31:0] instr, branch_target, jalr_target;
   logic [31:0] pc, pc_plus4, retired_count;
   logic        retire, halted, trap;
   logic [1:0]  trap_cause;

   int total = 0;
   int bad   = 0;

   // reference model state: m_state 0 running, 1 halted, 2 trapped
   logic [31:0] m_pc, m_cnt;
   int          m_state, m_cause;

   fetch_unit #(
      .WIDTH      (32),
      .RESET_PC   (32'h0),
      .IMEM_BYTES (IMEM),
      .CNT_W      (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .instr         (instr),
      .branch_taken  (branch_taken),
      .jal           (jal),
      .jalr          (jalr),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .retire        (retire),
      .halted        (halted),
      .trap          (trap),
      .trap_cause    (trap_cause),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   // what the fetch stage should do with the current inputs, from the ISA-level rules
   task automatic model_eval(output bit r, output int ns, output int nc, output logic [31:0] np);
      logic [63:0] tgt;
      r  = 1'b0;
      ns = m_state;
      nc = m_cause;
      np = m_pc;
      if (m_state == 0 && !stall) begin
         if (jalr)                     tgt = {32'b0, jalr_target & 32'hFFFF_FFFE};
         else if (jal || branch_taken) tgt = {32'b0, branch_target};
         else                          tgt = {32'b0, m_pc} + 64'd4;
         if (instr == 32'h0) begin
            ns = 2; nc = 3;
         end else if (tgt % 4 != 0) begin
            ns = 2; nc = 1;
         end else if (tgt >= IMEM) begin
            ns = 2; nc = 2;
         end else begin
            r = 1'b1;
            if (instr == HALT_WORD) ns = 1;
            else                    np = tgt[31:0];
         end
      end
   endtask

   // advance the model and the DUT by one clock edge
   task automatic tick();
      bit r; int ns, nc; logic [31:0] np;
      if (rst) begin
         m_pc = 32'h0; m_cnt = 32'h0; m_state = 0; m_cause = 0;
      end else begin
         model_eval(r, ns, nc, np);
         if (r) m_cnt = m_cnt + 32'd1;
         m_state = ns; m_cause = nc; m_pc = np;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic s, input logic [31:0] ins, input logic bt, input logic j,
                         input logic jr, input logic [31:0] btg, input logic [31:0] jtg);
      stall = s; instr = ins; branch_taken = bt; jal = j; jalr = jr;
      branch_target = btg; jalr_target = jtg;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(); tick();
      rst = 1'b0;
      set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
      total++; if (retired_count !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", retired_count); end
      total++; if (halted !== 1'b0 || trap !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", halted, trap); end
      total++; if (trap_cause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d want=0", trap_cause); end
      total++; if (retire !== 1'b1) begin bad++; $display("FAIL reset_retire got=%b want=1", retire); end
      total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h want=4", pc_plus4); end
   endtask

   task automatic test_sequential();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         total++; if (pc !== 32'(4*k)) begin bad++; $display("FAIL seq_pc got=%h want=%h", pc, 32'(4*k)); end
         if (k < 3) tick();
      end
      total++; if (retired_count !== 32'd3) begin bad++; $display("FAIL seq_cnt got=%0d want=3", retired_count); end
   endtask

   task automatic test_jal();
      do_reset();
      tick(); tick();
      set_in(1'b0, 32'h0100_006F, 1'b0, 1'b1, 1'b0, 32'd16, 32'h0);
      #1;
      total++; if (pc_plus4 !== 32'd12) begin bad++; $display("FAIL jal_link got=%h want=%h", pc_plus4, 32'd12); end
      total++; if (retire !== 1'b1) begin bad++; $display("FAIL jal_retire got=%b want=1", retire); end
      tick();
      total++; if (pc !== 32'd16) begin bad++; $display("FAIL jal_pc got=%h want=%h", pc, 32'd16); end
   endtask

   task automatic test_jalr();
      set_in(1'b0, 32'h0000_0067, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0D);
      tick();
      total++; if (pc !== 32'h0C) begin bad++; $display("FAIL jalr_pc got=%h want=%h", pc, 32'h0C); end
      total++; if (retired_count !== 32'd4) begin bad++; $display("FAIL jalr_cnt got=%0d want=4", retired_count); end
   endtask

   task automatic test_halt();
      do_reset();
      set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 4; k++) tick();
      set_in(1'b0, HALT_WORD, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      #1;
      total++; if (retire !== 1'b1) begin bad++; $display("FAIL halt_retire got=%b want=1", retire); end
      tick();
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", halted); end
      for (int k = 0; k < 10; k++) begin
         set_in(1'b0, $urandom | 32'h1, 1'($urandom), 1'($urandom), 1'($urandom), {$urandom_range(0, 1023), 2'b00}, $urandom);
         #1;
         total++; if (retire !== 1'b0) begin bad++; $display("FAIL halt_noretire got=%b want=0", retire); end
         tick();
         total++; if (pc !== 32'h10) begin bad++; $display("FAIL halt_pc got=%h want=%h", pc, 32'h10); end
      end
      total++; if (retired_count !== 32'd5) begin bad++; $display("FAIL halt_cnt got=%0d want=5", retired_count); end
   endtask

   task automatic test_traps();
      // misaligned branch target
      do_reset();
      tick();
      set_in(1'b0, NOP, 1'b1, 1'b0, 1'b0, 32'h12, 32'h0);
      #1;
      total++; if (retire !== 1'b0) begin bad++; $display("FAIL mis_retire got=%b want=0", retire); end
      tick();
      total++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin bad++; $display("FAIL mis_trap got=%b/%0d want=1/1", trap, trap_cause); end
      total++; if (pc !== 32'h4 || retired_count !== 32'd1) begin bad++; $display("FAIL mis_hold got=%h/%0d want=4/1", pc, retired_count); end
      // sequential fall-off at the top of instruction memory
      do_reset();
      set_in(1'b0, NOP, 1'b0, 1'b1, 1'b0, 32'(IMEM - 4), 32'h0);
      tick();
      set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      total++; if (trap !== 1'b1 || trap_cause !== 2'd2) begin bad++; $display("FAIL range_trap got=%b/%0d want=1/2", trap, trap_cause); end
      total++; if (pc !== 32'(IMEM - 4) || retired_count !== 32'd1) begin bad++; $display("FAIL range_hold got=%h/%0d want=%h/1", pc, retired_count, 32'(IMEM - 4)); end
      // jalr far beyond memory
      do_reset();
      set_in(1'b0, NOP, 1'b0, 1'b0, 1'b1, 32'h0, 32'(IMEM) | 32'h1);
      tick();
      total++; if (trap_cause !== 2'd2) begin bad++; $display("FAIL jalr_range got=%0d want=2", trap_cause); end
      // all-zero instruction word
      do_reset();
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      total++; if (trap !== 1'b1 || trap_cause !== 2'd3 || pc !== 32'h0) begin bad++; $display("FAIL zero_trap got=%b/%0d/%h want=1/3/0", trap, trap_cause, pc); end
   endtask

   task automatic test_stall_reset();
      do_reset();
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, NOP, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
         #1;
         total++; if (retire !== 1'b0) begin bad++; $display("FAIL stall_retire got=%b want=0", retire); end
         tick();
         total++; if (pc !== 32'h8 || retired_count !== 32'd2) begin bad++; $display("FAIL stall_hold got=%h/%0d want=8/2", pc, retired_count); end
      end
      set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      total++; if (trap !== 1'b1) begin bad++; $display("FAIL stall_trap got=%b want=1", trap); end
      rst = 1'b1;
      stall = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (trap !== 1'b0 || halted !== 1'b0 || trap_cause !== 2'd0) begin bad++; $display("FAIL rst_state got=%b%b/%0d want=00/0", trap, halted, trap_cause); end
      total++; if (pc !== 32'h0 || retired_count !== 32'd0) begin bad++; $display("FAIL rst_regs got=%h/%0d want=0/0", pc, retired_count); end
   endtask

   task automatic test_random();
      bit er; int ns, nc; logic [31:0] np;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         rst = ($urandom_range(0, 99) < 2) || (m_state != 0 && $urandom_range(0, 3) == 0);
         stall = ($urandom_range(0, 4) == 0);
         case ($urandom_range(0, 24))
            0:       instr = 32'h0;
            1:       instr = HALT_WORD;
            default: instr = $urandom | 32'h1;
         endcase
         jalr         = ($urandom_range(0, 7) == 0);
         jal          = ($urandom_range(0, 7) == 0);
         branch_taken = ($urandom_range(0, 5) == 0);
         for (int t = 0; t < 2; t++) begin
            logic [31:0] v;
            case ($urandom_range(0, 9))
               7:       v = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
               8:       v = 32'($urandom_range(IMEM, 2 * IMEM));
               9:       v = $urandom;
               default: v = {$urandom_range(0, 1023), 2'b00};
            endcase
            if (t == 0) branch_target = v;
            else        jalr_target   = v | 32'($urandom_range(0, 1));
         end
         #1;
         model_eval(er, ns, nc, np);
         total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h want=%h", k, pc, m_pc); end
         total++; if (pc_plus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_pc4 cyc=%0d got=%h want=%h", k, pc_plus4, m_pc + 32'd4); end
         total++; if (retire !== er) begin bad++; $display("FAIL rnd_retire cyc=%0d got=%b want=%b", k, retire, er); end
         total++; if (retired_count !== m_cnt) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", k, retired_count, m_cnt); end
         total++; if (halted !== (m_state == 1) || trap !== (m_state == 2)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%b%b want=%b%b", k, halted, trap, m_state == 1, m_state == 2); end
         total++; if (trap_cause !== 2'(m_cause)) begin bad++; $display("FAIL rnd_cause cyc=%0d got=%0d want=%0d", k, trap_cause, m_cause); end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      m_pc = 32'h0; m_cnt = 32'h0; m_state = 0; m_cause = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_sequential();
      test_jal();
      test_jalr();
      test_halt();
      test_traps();
      test_stall_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
